// File: rtl/orga_pkg.sv
// Shared types and default widths for the decode slice.
// Decoded records are sized to the widest supported configuration; modules use the low bits.
package orga_pkg;

  localparam int DEF_INST_SIZE     = 16;
  localparam int DEF_OPCODE_BITS   = 5;
  localparam int DEF_REGISTER_BITS = 3;
  localparam int DEF_IMM_BITS      = 8;
  localparam int DEF_DATA_BITS     = 8;
  localparam int DEF_IMM_SIGNED    = 0;

  localparam int MAX_OPCODE_BITS   = 8;
  localparam int MAX_REGISTER_BITS = 8;
  localparam int MAX_IMM_BITS      = 32;
  localparam int MAX_DATA_BITS     = 32;

  typedef struct packed {
    logic [MAX_OPCODE_BITS-1:0]   opcode;
    logic [MAX_REGISTER_BITS-1:0] rx;
    logic [MAX_REGISTER_BITS-1:0] ry;
    logic [MAX_IMM_BITS-1:0]      imm;
    logic [MAX_DATA_BITS-1:0]     imm_ext;
    logic                         illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Widen an imm_bits-wide value to data_bits, replicating the top bit when sign_ext is set.
  function automatic logic [MAX_DATA_BITS-1:0] extend_imm(
    input logic [MAX_IMM_BITS-1:0] raw,
    input int                      imm_bits,
    input int                      data_bits,
    input logic                    sign_ext
  );
    logic [MAX_DATA_BITS-1:0] res;
    logic                     fill;
    res  = '0;
    fill = 1'b0;
    for (int i = 0; i < MAX_IMM_BITS; i++) begin
      if (i == imm_bits - 1) fill = sign_ext & raw[i];
    end
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < imm_bits)       res[i] = raw[i];
      else if (i < data_bits) res[i] = fill;
    end
    return res;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and execute.
// The stage takes the slave view; the surrounding pipeline takes the master view.
interface decode_stage_if
  import orga_pkg::*;
#(
  parameter int INST_SIZE     = DEF_INST_SIZE,
  parameter int OPCODE_BITS   = DEF_OPCODE_BITS,
  parameter int REGISTER_BITS = DEF_REGISTER_BITS,
  parameter int IMM_BITS      = DEF_IMM_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS
);

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [INST_SIZE-1:0]     inst;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_BITS-1:0]   opcode;
  logic [REGISTER_BITS-1:0] rx;
  logic [REGISTER_BITS-1:0] ry;
  logic [IMM_BITS-1:0]      imm;
  logic [DATA_BITS-1:0]     imm_ext;
  logic                     illegal;
  logic [15:0]              decoded_count;

  modport slave (
    input  flush, in_valid, inst, out_ready,
    output in_ready, out_valid, opcode, rx, ry, imm, imm_ext, illegal, decoded_count
  );

  modport master (
    output flush, in_valid, inst, out_ready,
    input  in_ready, out_valid, opcode, rx, ry, imm, imm_ext, illegal, decoded_count
  );

endinterface

// File: rtl/decode_fields.sv
// Combinational instruction splitter: slices fields, extends the immediate,
// and looks the opcode up in the legality mask.
module decode_fields
  import orga_pkg::*;
#(
  parameter int INST_SIZE     = DEF_INST_SIZE,
  parameter int OPCODE_BITS   = DEF_OPCODE_BITS,
  parameter int REGISTER_BITS = DEF_REGISTER_BITS,
  parameter int IMM_BITS      = DEF_IMM_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int IMM_SIGNED    = DEF_IMM_SIGNED,
  parameter logic [2**OPCODE_BITS-1:0] LEGAL_MASK = '1
) (
  input  logic [INST_SIZE-1:0] inst,
  output decoded_t             dec
);

  localparam int RX_MSB = INST_SIZE - OPCODE_BITS - 1;
  localparam int RY_MSB = RX_MSB - REGISTER_BITS;

  logic [OPCODE_BITS-1:0]  op_raw;
  logic [MAX_IMM_BITS-1:0] imm_raw;

  // NOTE: every variable written here gets a default first, so no path through the block can infer a latch.
  always_comb begin
    dec     = '0;
    imm_raw = '0;
    op_raw  = inst[INST_SIZE-1 -: OPCODE_BITS];

    imm_raw[IMM_BITS-1:0]            = inst[IMM_BITS-1:0];
    dec.opcode[OPCODE_BITS-1:0]      = op_raw;
    dec.rx[REGISTER_BITS-1:0]        = inst[RX_MSB -: REGISTER_BITS];
    dec.ry[REGISTER_BITS-1:0]        = inst[RY_MSB -: REGISTER_BITS];
    dec.imm                          = imm_raw;
    dec.imm_ext                      = extend_imm(imm_raw, IMM_BITS, DATA_BITS, IMM_SIGNED != 0);
    dec.illegal                      = ~LEGAL_MASK[op_raw];
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: a two-entry head/skid buffer with valid/ready on both sides,
// flush on redirect, and a wrapping count of delivered instructions.
module decode_stage
  import orga_pkg::*;
#(
  parameter int INST_SIZE     = DEF_INST_SIZE,
  parameter int OPCODE_BITS   = DEF_OPCODE_BITS,
  parameter int REGISTER_BITS = DEF_REGISTER_BITS,
  parameter int IMM_BITS      = DEF_IMM_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int IMM_SIGNED    = DEF_IMM_SIGNED,
  parameter logic [2**OPCODE_BITS-1:0] LEGAL_MASK = '1
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  if (OPCODE_BITS + 2 * REGISTER_BITS > INST_SIZE) begin : g_bad_fields
    $fatal(1, "decode_stage: opcode and register fields exceed INST_SIZE");
  end
  if (IMM_BITS > INST_SIZE - OPCODE_BITS) begin : g_bad_imm
    $fatal(1, "decode_stage: IMM_BITS overlaps the opcode field");
  end
  if (DATA_BITS < IMM_BITS) begin : g_bad_data
    $fatal(1, "decode_stage: DATA_BITS narrower than IMM_BITS");
  end
  if (OPCODE_BITS > MAX_OPCODE_BITS || REGISTER_BITS > MAX_REGISTER_BITS ||
      IMM_BITS > MAX_IMM_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_max
    $fatal(1, "decode_stage: field widths exceed orga_pkg maxima");
  end

  occ_e        state;
  decoded_t    head_q;
  decoded_t    skid_q;
  decoded_t    dec;
  logic [15:0] count_q;
  logic        accept;
  logic        pop;
  logic        unused_head;

  decode_fields #(
    .INST_SIZE     (INST_SIZE),
    .OPCODE_BITS   (OPCODE_BITS),
    .REGISTER_BITS (REGISTER_BITS),
    .IMM_BITS      (IMM_BITS),
    .DATA_BITS     (DATA_BITS),
    .IMM_SIGNED    (IMM_SIGNED),
    .LEGAL_MASK    (LEGAL_MASK)
  ) u_fields (
    .inst (bus.inst),
    .dec  (dec)
  );

  // Both handshake flags come from the state register alone, so out_ready never reaches in_ready.
  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // NOTE: state and both data registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      // NOTE: the two data registers are reset because their contents drive the outputs directly.
      head_q  <= '0;
      skid_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) count_q <= count_q + 16'd1;

      if (bus.flush) begin
        state <= EMPTY;
      end else begin
        unique case (state)
          EMPTY: begin
            if (accept) begin
              head_q <= dec;
              state  <= ONE;
            end
          end
          ONE: begin
            if (accept && !pop) begin
              skid_q <= dec;
              state  <= TWO;
            end else if (pop && !accept) begin
              state  <= EMPTY;
            end else if (pop && accept) begin
              head_q <= dec;
            end
          end
          TWO: begin
            if (pop) begin
              head_q <= skid_q;
              state  <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.opcode        = head_q.opcode[OPCODE_BITS-1:0];
  assign bus.rx            = head_q.rx[REGISTER_BITS-1:0];
  assign bus.ry            = head_q.ry[REGISTER_BITS-1:0];
  assign bus.imm           = head_q.imm[IMM_BITS-1:0];
  assign bus.imm_ext       = head_q.imm_ext[DATA_BITS-1:0];
  assign bus.illegal       = head_q.illegal;
  assign bus.decoded_count = count_q;

  // Upper record bits beyond the configured widths are always zero and intentionally dropped.
  assign unused_head = ^head_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: two instances (sign- and zero-extending) share stimulus;
// accepted instructions are modelled with plain arithmetic and checked in order at the output.
module tb_decode_stage;
  import orga_pkg::*;

  localparam logic [31:0] LEGAL = 32'h7FFF_FFBF; // opcodes 31 and 6 are illegal

  typedef struct {
    logic [31:0] opcode;
    logic [31:0] rx;
    logic [31:0] ry;
    logic [31:0] imm;
    logic [31:0] ext_s;
    logic [31:0] ext_z;
    logic [31:0] illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] inst = '0;

  exp_t        q[$];
  logic [31:0] model_count = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.DATA_BITS(16)) bus_s ();
  decode_stage_if #(.DATA_BITS(16)) bus_z ();

  assign bus_s.flush     = flush;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.inst      = inst;
  assign bus_s.out_ready = out_ready;
  assign bus_z.flush     = flush;
  assign bus_z.in_valid  = in_valid;
  assign bus_z.inst      = inst;
  assign bus_z.out_ready = out_ready;

  decode_stage #(
    .INST_SIZE(16), .OPCODE_BITS(5), .REGISTER_BITS(3), .IMM_BITS(8),
    .DATA_BITS(16), .IMM_SIGNED(1), .LEGAL_MASK(LEGAL)
  ) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  decode_stage #(
    .INST_SIZE(16), .OPCODE_BITS(5), .REGISTER_BITS(3), .IMM_BITS(8),
    .DATA_BITS(16), .IMM_SIGNED(0), .LEGAL_MASK(LEGAL)
  ) u_dut_z (.clk(clk), .rst_n(rst_n), .bus(bus_z));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [15:0] w);
    exp_t        e;
    logic [31:0] v;
    v         = 32'(w);
    e.opcode  = v / 2048;
    e.rx      = (v / 256) % 8;
    e.ry      = (v / 32) % 8;
    e.imm     = v % 256;
    e.ext_z   = e.imm;
    e.ext_s   = (e.imm >= 128) ? e.imm + 32'hFF00 : e.imm;
    e.illegal = (e.opcode == 31 || e.opcode == 6) ? 32'd1 : 32'd0;
    return e;
  endfunction

  // Monitor: compares the presented head against the scoreboard every cycle, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("out_valid", 32'(bus_s.out_valid), 32'(q.size() != 0));
        check("out_valid_z", 32'(bus_z.out_valid), 32'(q.size() != 0));
        check("in_ready", 32'(bus_s.in_ready), 32'(q.size() < 2));
        check("decoded_count", 32'(bus_s.decoded_count), model_count % 65536);
        if (bus_s.out_valid && q.size() != 0) begin
          check("opcode", 32'(bus_s.opcode), q[0].opcode);
          check("rx", 32'(bus_s.rx), q[0].rx);
          check("ry", 32'(bus_s.ry), q[0].ry);
          check("imm", 32'(bus_s.imm), q[0].imm);
          check("imm_ext_signed", 32'(bus_s.imm_ext), q[0].ext_s);
          check("imm_ext_zero", 32'(bus_z.imm_ext), q[0].ext_z);
          check("illegal", 32'(bus_s.illegal), q[0].illegal);
          if (out_ready) begin
            void'(q.pop_front());
            model_count++;
          end
        end
        if (flush) q.delete();
      end
    end
  end

  // One clock: record an acceptance at the edge, then move off the edge for new drives.
  task automatic tick();
    @(posedge clk);
    if (rst_n && in_valid && bus_s.in_ready && !flush) q.push_back(model(inst));
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    inst     = w;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clk);
      acc = rst_n && bus_s.in_ready && !flush;
      if (acc) q.push_back(model(w));
      #1;
    end
    check("send_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    tick();
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;

    // Reset values
    #1;
    check("rst_out_valid", 32'(bus_s.out_valid), 32'd0);
    check("rst_count", 32'(bus_s.decoded_count), 32'd0);
    check("rst_opcode", 32'(bus_s.opcode), 32'd0);
    check("rst_imm_ext", 32'(bus_s.imm_ext), 32'd0);
    check("rst_illegal", 32'(bus_s.illegal), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(bus_s.in_ready), 32'd1);

    // Streaming with the consumer always ready
    out_ready = 1'b1;
    send(16'h8A5F);
    send(16'h0123);
    drain();

    // Back-pressure: third instruction waits until the consumer releases
    base      = model_count;
    out_ready = 1'b0;
    send(16'h1234);
    send(16'h2345);
    fork
      send(16'h3456);
      begin
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    check("backpressure_count", 32'(bus_s.decoded_count), base + 3);

    // Immediate extension and illegal opcodes flow through
    send(16'h0080);
    send(16'h007F);
    send(16'hF800);
    send(16'h3081);
    drain();

    // Flush while full with a simultaneous input
    out_ready = 1'b0;
    send(16'h4111);
    send(16'h5222);
    base     = model_count;
    in_valid = 1'b1;
    inst     = 16'h6333;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush_out_valid", 32'(bus_s.out_valid), 32'd0);
    check("flush_count", 32'(bus_s.decoded_count), base);
    drain();

    // Asynchronous reset in the middle of a stream
    out_ready = 1'b0;
    send(16'h7444);
    send(16'h0555);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus_s.out_valid), 32'd0);
    check("async_rst_count", 32'(bus_s.decoded_count), 32'd0);
    q.delete();
    model_count = 0;
    tick();
    rst_n = 1'b1;
    #1;
    check("async_rst_in_ready", 32'(bus_s.in_ready), 32'd1);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      inst      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
